// File: rtl/wb_regfile.sv
// Write-back stage register file: 2**ADDR_W x DATA_W registers, two combinational read ports,
// write-data select and committed-write counter. Define WB_REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        WB_WB,
  input  logic [DATA_W-1:0] ALUOut_WB,
  input  logic [DATA_W-1:0] DataMEM_RD_WB,
  input  logic [ADDR_W-1:0] WN_WB,
  input  logic [ADDR_W-1:0] RN1,
  input  logic [ADDR_W-1:0] RN2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [DATA_W-1:0] WD,
  output logic [31:0]       wb_count
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [31:0]       count;
  logic              mem_to_reg;
  logic              reg_write;
  logic              wr_en;

  assign mem_to_reg = WB_WB[1];
  assign reg_write  = WB_WB[0];
  assign WD         = mem_to_reg ? DataMEM_RD_WB : ALUOut_WB;

  // Register 0 is never written, so it keeps its reset value of zero.
  assign wr_en = reg_write && (WN_WB != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[WN_WB] <= WD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (wr_en) begin
      count <= count + 32'd1;
    end
  end

  assign wb_count = count;

`ifdef WB_REGFILE_BYPASS_EN
  assign RD1 = (wr_en && (RN1 == WN_WB)) ? WD : regs[RN1];
  assign RD2 = (wr_en && (RN2 == WN_WB)) ? WD : regs[RN2];
`else
  assign RD1 = regs[RN1];
  assign RD2 = regs[RN2];
`endif

endmodule
